// File: rtl/noc_router_pkg.sv
// Shared definitions for the cardinal NoC router: port/VC indices and flit header layout.
// Types and constants only; no logic.
package noc_router_pkg;

  localparam int N_PORTS  = 5;
  localparam int PORT_UP    = 0;
  localparam int PORT_DOWN  = 1;
  localparam int PORT_LEFT  = 2;
  localparam int PORT_RIGHT = 3;
  localparam int PORT_PE    = 4;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  localparam int FLIT_W      = 64;
  localparam int FLIT_VC_BIT = 63;
  localparam int FLIT_DIRX   = 62;
  localparam int FLIT_DIRY   = 61;
  localparam int FLIT_HOPX_HI = 55;
  localparam int FLIT_HOPX_LO = 52;
  localparam int FLIT_HOPY_HI = 51;
  localparam int FLIT_HOPY_LO = 48;

  // Upper 16 bits of a flit; bits 60:56 are reserved.
  typedef struct packed {
    logic       vc;
    logic       dir_x;
    logic       dir_y;
    logic [4:0] rsvd;
    logic [3:0] hop_x;
    logic [3:0] hop_y;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [47:0] payload;
  } flit_t;

endpackage

// File: rtl/rr_pick_onehot.sv
// Round-robin pick: first request at or above the one-hot priority, wrapping.
// Purely combinational, zero latency; no backpressure (caller gates the result).
module rr_pick_onehot #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_prio;
  logic [2*N-1:0] dbl_gnt;

  // Subtracting the pointer from the doubled request vector clears exactly the
  // first set bit at or above it; masking isolates that bit, folding undoes the wrap.
  assign dbl_req  = {req, req};
  assign dbl_prio = {{N{1'b0}}, prio};
  assign dbl_gnt  = dbl_req & ~(dbl_req - dbl_prio);
  assign gnt      = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];

endmodule

// File: rtl/vc_output_port_scheduler.sv
// Per-output-port round-robin scheduler for even/odd VCs; polarity picks the competing VC.
// Grant is same-cycle combinational; a full output buffer on the active VC freezes grant and state.
module vc_output_port_scheduler
  import noc_router_pkg::*;
#(
  parameter int N_REQ        = N_PORTS,
  parameter int CNT_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic [N_REQ-1:0] req_even,
  input  logic [N_REQ-1:0] req_odd,
  input  logic             out_full_even,
  input  logic             out_full_odd,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             gnt_vc,
  output logic [N_REQ-1:0] prio_even,
  output logic [N_REQ-1:0] prio_odd,
  output logic             starve_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [31:0]      LIMIT_U  = STARVE_LIMIT;
  localparam logic [N_REQ-1:0] PRIO_RST = N_REQ'(1);

  logic [N_REQ-1:0]            prio_even_q;
  logic [N_REQ-1:0]            prio_odd_q;
  logic [N_REQ-1:0][CNT_W-1:0] cnt_even_q;
  logic [N_REQ-1:0][CNT_W-1:0] cnt_odd_q;
  logic                        starve_q;

  logic [N_REQ-1:0]            act_req;
  logic [N_REQ-1:0]            act_prio;
  logic                        act_full;
  logic                        eligible;
  logic [N_REQ-1:0]            pick;
  logic [N_REQ-1:0]            prio_next;
  logic [N_REQ-1:0][CNT_W-1:0] cnt_act;
  logic [N_REQ-1:0][CNT_W-1:0] cnt_upd;
  logic                        starve_hit;

  assign act_req  = polarity ? req_odd      : req_even;
  assign act_prio = polarity ? prio_odd_q   : prio_even_q;
  assign act_full = polarity ? out_full_odd : out_full_even;
  assign eligible = ~act_full & ~reset;

  rr_pick_onehot #(.N(N_REQ)) u_pick (
    .req  (act_req),
    .prio (act_prio),
    .gnt  (pick)
  );

  assign gnt       = eligible ? pick : '0;
  assign gnt_valid = |gnt;
  assign gnt_vc    = polarity ? VC_ODD : VC_EVEN;
  assign prio_even = prio_even_q;
  assign prio_odd  = prio_odd_q;
  assign starve_err = starve_q;

  // The winner moves to lowest priority: the pointer lands just past it.
  assign prio_next = {gnt[N_REQ-2:0], gnt[N_REQ-1]};

  always_comb begin
    cnt_act    = polarity ? cnt_odd_q : cnt_even_q;
    cnt_upd    = cnt_act;
    starve_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i] || !act_req[i]) begin
        cnt_upd[i] = '0;
      end else if (cnt_act[i] != CNT_MAX) begin
        cnt_upd[i] = cnt_act[i] + CNT_W'(1);
      end
      if (32'(cnt_upd[i]) >= LIMIT_U) begin
        starve_hit = eligible;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_even_q <= PRIO_RST;
      prio_odd_q  <= PRIO_RST;
      cnt_even_q  <= '0;
      cnt_odd_q   <= '0;
      starve_q    <= 1'b0;
    end else begin
      if (eligible) begin
        if (polarity) begin
          cnt_odd_q <= cnt_upd;
          if (gnt_valid) prio_odd_q <= prio_next;
        end else begin
          cnt_even_q <= cnt_upd;
          if (gnt_valid) prio_even_q <= prio_next;
        end
      end
      if (starve_hit) starve_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_output_port_scheduler.sv
// Directed table-driven bench for vc_output_port_scheduler plus multi-cycle corner sequences.
module tb_vc_output_port_scheduler;

  logic       clk;
  logic       reset;
  logic       polarity;
  logic [4:0] req_even, req_odd;
  logic       out_full_even, out_full_odd;
  logic [4:0] gnt, prio_even, prio_odd;
  logic       gnt_valid, gnt_vc, starve_err;

  int n_cmp = 0;
  int n_bad = 0;

  vc_output_port_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .polarity      (polarity),
    .req_even      (req_even),
    .req_odd       (req_odd),
    .out_full_even (out_full_even),
    .out_full_odd  (out_full_odd),
    .gnt           (gnt),
    .gnt_valid     (gnt_valid),
    .gnt_vc        (gnt_vc),
    .prio_even     (prio_even),
    .prio_odd      (prio_odd),
    .starve_err    (starve_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       pol;
    logic [4:0] re;
    logic [4:0] ro;
    logic       fe;
    logic       fo;
    logic [4:0] g;
    logic [4:0] pe;
    logic [4:0] po;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic pol, input logic [4:0] re, input logic [4:0] ro,
                     input logic fe, input logic fo, input logic [4:0] g,
                     input logic [4:0] pe, input logic [4:0] po);
    vec_t v;
    v.rst = rst; v.pol = pol; v.re = re; v.ro = ro; v.fe = fe; v.fo = fo;
    v.g = g; v.pe = pe; v.po = po;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_even = 5'b11111; req_odd = 5'b11111;
    out_full_even = 1'b0; out_full_odd = 1'b0; polarity = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_prio_even", 32'(prio_even), 32'h01);
    chk("rst_prio_odd", 32'(prio_odd), 32'h01);
    chk("rst_starve", 32'(starve_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req_even = '0; req_odd = '0;
  endtask

  task automatic drive(input logic pol, input logic [4:0] re, input logic [4:0] ro,
                       input logic fe, input logic fo);
    polarity = pol; req_even = re; req_odd = ro;
    out_full_even = fe; out_full_odd = fo;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // rst pol re       ro       fe fo  gnt      prio_even prio_odd
    add(1, 0, 5'b00100, 5'b00000, 0, 0, 5'b00100, 5'b01000, 5'b00001);
    add(1, 0, 5'b11111, 5'b00000, 0, 0, 5'b00001, 5'b00010, 5'b00001);
    add(0, 0, 5'b11111, 5'b00000, 0, 0, 5'b00010, 5'b00100, 5'b00001);
    add(0, 0, 5'b11111, 5'b00000, 0, 0, 5'b00100, 5'b01000, 5'b00001);
    add(0, 0, 5'b11111, 5'b00000, 0, 0, 5'b01000, 5'b10000, 5'b00001);
    add(0, 0, 5'b11111, 5'b00000, 0, 0, 5'b10000, 5'b00001, 5'b00001);
    add(0, 1, 5'b01100, 5'b00000, 0, 0, 5'b00000, 5'b00001, 5'b00001);
    add(0, 0, 5'b01100, 5'b00000, 0, 0, 5'b00100, 5'b01000, 5'b00001);
    add(0, 1, 5'b01100, 5'b00000, 0, 0, 5'b00000, 5'b01000, 5'b00001);
    add(0, 0, 5'b01100, 5'b00000, 0, 0, 5'b01000, 5'b10000, 5'b00001);
    add(0, 1, 5'b01100, 5'b00000, 0, 0, 5'b00000, 5'b10000, 5'b00001);
    add(0, 0, 5'b01100, 5'b00000, 0, 0, 5'b00100, 5'b01000, 5'b00001);
    add(0, 1, 5'b00000, 5'b10010, 0, 0, 5'b00010, 5'b01000, 5'b00100);
    add(0, 1, 5'b00000, 5'b10010, 0, 0, 5'b10000, 5'b01000, 5'b00001);
    add(0, 1, 5'b00000, 5'b10010, 0, 0, 5'b00010, 5'b01000, 5'b00100);
    add(0, 0, 5'b01100, 5'b00000, 1, 0, 5'b00000, 5'b01000, 5'b00100);
    add(0, 1, 5'b01100, 5'b00001, 1, 0, 5'b00001, 5'b01000, 5'b00010);
    add(0, 1, 5'b00000, 5'b00001, 0, 1, 5'b00000, 5'b01000, 5'b00010);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      @(negedge clk);
      drive(vecs[k].pol, vecs[k].re, vecs[k].ro, vecs[k].fe, vecs[k].fo);
      #1;
      chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(vecs[k].g));
      chk($sformatf("v%0d_gnt_valid", k), 32'(gnt_valid), 32'(|vecs[k].g));
      if (vecs[k].g != 5'b0) chk($sformatf("v%0d_gnt_vc", k), 32'(gnt_vc), 32'(vecs[k].pol));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_prio_even", k), 32'(prio_even), 32'(vecs[k].pe));
      chk($sformatf("v%0d_prio_odd", k), 32'(prio_odd), 32'(vecs[k].po));
      chk($sformatf("v%0d_starve", k), 32'(starve_err), 32'h0);
    end

    // Full-buffer freeze: counter and pointer hold, release grants in first even cycle.
    do_reset();
    @(negedge clk); drive(1'b0, 5'b00011, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("frz_pre_cnt1", 32'(dut.cnt_even_q[1]), 32'd1);
    chk("frz_pre_prio", 32'(prio_even), 32'h02);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); drive(1'b0, 5'b00010, '0, 1'b1, 1'b0);
      #1;
      chk("frz_gnt", 32'(gnt), 32'h0);
      @(posedge clk); #1;
      chk("frz_prio", 32'(prio_even), 32'h02);
      chk("frz_cnt1", 32'(dut.cnt_even_q[1]), 32'd1);
    end
    @(negedge clk); drive(1'b1, 5'b00010, '0, 1'b0, 1'b0);
    #1;
    chk("frz_odd_gnt", 32'(gnt), 32'h0);
    @(negedge clk); drive(1'b0, 5'b00010, '0, 1'b0, 1'b0);
    #1;
    chk("frz_rel_gnt", 32'(gnt), 32'h02);
    @(posedge clk); #1;
    chk("frz_rel_prio", 32'(prio_even), 32'h04);
    chk("frz_rel_cnt1", 32'(dut.cnt_even_q[1]), 32'd0);

    // Stuck pointer starves requester 1; flag rises on the 8th denied cycle and sticks.
    do_reset();
    force dut.prio_even_q = 5'b00001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); drive(1'b0, 5'b00011, '0, 1'b0, c[0]);
      #1;
      chk("stv_gnt", 32'(gnt), 32'h01);
      @(posedge clk); #1;
      chk("stv_cnt1", 32'(dut.cnt_even_q[1]), 32'(c));
      if (c == 7) chk("stv_before", 32'(starve_err), 32'h0);
      if (c == 8) chk("stv_set", 32'(starve_err), 32'h1);
    end
    release dut.prio_even_q;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(c[0], '0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("stv_sticky", 32'(starve_err), 32'h1);
    end
    do_reset();
    @(posedge clk); #1;
    chk("stv_cleared", 32'(starve_err), 32'h0);

    // Asynchronous reset mid-stream clears grant, pointer and counters before any edge.
    @(negedge clk); drive(1'b0, 5'b00110, '0, 1'b0, 1'b0);
    #1; chk("mid_g1", 32'(gnt), 32'h02);
    @(negedge clk);
    #1; chk("mid_g2", 32'(gnt), 32'h04);
    @(posedge clk); #1;
    chk("mid_prio", 32'(prio_even), 32'h08);
    chk("mid_cnt1", 32'(dut.cnt_even_q[1]), 32'd1);
    @(negedge clk); drive(1'b0, 5'b11111, '0, 1'b0, 1'b0);
    #1; chk("mid_g3", 32'(gnt), 32'h08);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(gnt_valid), 32'h0);
    chk("mid_rst_prio", 32'(prio_even), 32'h01);
    chk("mid_rst_cnt", 32'(dut.cnt_even_q), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_post_gnt", 32'(gnt), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
